alu_md: RTL and testbench
=========================

ALU_MD -- requirements
Module: alu_md

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the datapath width of A, B, Result, HI and LO; legal values are 8, 16, 32 and 64.
REQ-002 Parameter SH_W, default $clog2(WIDTH), SHALL set the shift-amount width, taken from A[SH_W-1:0]; it is derived and is not overridden.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 A  input  WIDTH  operand A; rs value, or shift amount for shift ops.
REQ-006 B  input  WIDTH  operand B; rt value or extended immediate.
REQ-007 ALUOp_EX  input  5  operation select.
REQ-008 start  input  1  request qualifier for multiply/divide/mthi/mtlo ops.
REQ-009 Result  output  WIDTH  combinational result.
REQ-010 Over, Zero, Great, Less  output  1 each  combinational overflow and signed-compare flags.
REQ-011 Busy  output  1  multiply/divide engine occupied.
REQ-012 Done  output  1  one-cycle completion pulse.
REQ-013 HI, LO  output  WIDTH each  architectural HI/LO registers.

Function
REQ-014 Codes 00000-10001 SHALL be combinational: add, sub, or, and, xor, nor, sll, srl, sra, sllv, srlv, srav, slt, slti, sltu, 01111 sltiu, addu, subu, with every shift amount taken from A[SH_W-1:0].
REQ-015 Any code outside REQ-014 and REQ-016 to REQ-017 SHALL drive Result to the unsigned A<B compare.
REQ-016 Codes 10010 mult, 10011 multu, 10100 div, 10101 divu, 10110 mthi and 10111 mtlo SHALL act only in a cycle with start=1 and Busy=0; in every other cycle they are ignored and HI/LO are unchanged.
REQ-017 Code 11000 mfhi SHALL drive Result=HI and code 11001 mflo SHALL drive Result=LO, both combinationally, regardless of Busy; the consumer stalls on Busy.
REQ-018 Over SHALL be 1 only for add or sub when the two's-complement result overflows WIDTH bits; it is 0 for every other code.
REQ-019 Zero, Great and Less SHALL be signed A==B, A>B and A<B for every code.
REQ-020 mthi and mtlo SHALL load A into HI or LO at the accepting edge, leave Busy at 0 and pulse no Done.
REQ-021 An accepted mult or multu SHALL latch A and B, raise Busy from the next cycle, and hold Busy for exactly WIDTH cycles as an iterative shift-add engine.
REQ-022 An accepted div or divu SHALL latch A and B and hold Busy for exactly WIDTH+1 cycles: WIDTH restoring steps followed by one sign-fixup cycle.
REQ-023 At the edge ending the last Busy cycle, HI/LO SHALL load the result and Busy SHALL fall; Done SHALL be 1 for exactly the following cycle.
REQ-024 A multiply SHALL write the 2*WIDTH-bit product as {HI,LO}, signed for mult and unsigned for multu.
REQ-025 A divide SHALL write the quotient to LO and the remainder to HI.
REQ-026 Signed quotients SHALL truncate toward zero, and the signed remainder SHALL take the sign of the dividend.
REQ-027 Divide by zero SHALL set LO to all ones and HI to the dividend, with the same latency as a normal divide.
REQ-028 Signed -2^(WIDTH-1) / -1 SHALL set LO to -2^(WIDTH-1) and HI to 0.
REQ-029 Operand changes on A and B while Busy=1 SHALL NOT affect the operation in flight.
REQ-030 The engine state SHALL be IDLE -> MUL(WIDTH) or DIV(WIDTH) -> FIX (divide only) -> IDLE, with Done asserted in the first IDLE cycle.
REQ-031 A start in the Done cycle SHALL be accepted, giving back-to-back operations.

Reset
REQ-032 reset=1 SHALL clear HI, LO, Busy, Done and the engine state to 0/IDLE at the next edge.
REQ-033 Reset SHALL abort any in-flight operation with no HI/LO update and no Done pulse.
REQ-034 Reset SHALL take priority over a simultaneous start.

Verification
REQ-035 add 0x7FFFFFFF+0x00000001 -> Result=0x80000000, Over=1; addu of the same operands -> Over=0; sra with B=0x80000000, A=4 -> Result=0xF8000000.
REQ-036 mult 0xFFFFFFFF x 0x00000002 -> Busy high for 32 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE and a 1-cycle Done; multu of the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-037 div -7/2 -> after 33 Busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 7/2 -> LO=3, HI=1.
REQ-038 div 5/0 -> LO=0xFFFFFFFF, HI=5; div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-039 start of mult in Busy cycle 3 and mtlo while Busy -> both ignored, first result intact; reset in Busy cycle 10 -> next cycle Busy=0, HI=LO=0, no Done.
REQ-040 With WIDTH=16: multu 0xFFFF x 0xFFFF -> HI=0xFFFE, LO=0x0001 after 16 Busy cycles; sll with A=0x0013 -> shift amount 3.

Source files
------------

// File: rtl/alu_md_if.sv
// ALU / multiply-divide bus: operands, operation select, start qualifier and all results.
interface alu_md_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [4:0]       ALUOp_EX;
    logic             start;
    logic [WIDTH-1:0] Result;
    logic             Over;
    logic             Zero;
    logic             Great;
    logic             Less;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output A, B, ALUOp_EX, start,
        input  Result, Over, Zero, Great, Less, Busy, Done, HI, LO
    );

    modport slave (
        input  A, B, ALUOp_EX, start,
        output Result, Over, Zero, Great, Less, Busy, Done, HI, LO
    );
endinterface

// File: rtl/alu_md.sv
// Combinational ALU plus an iterative multiply/divide engine owning the HI/LO registers.
// Multiply: WIDTH shift-add steps on operand magnitudes, sign applied when writing HI/LO.
// Divide: WIDTH restoring steps on magnitudes, then one fixup cycle for signs and div-by-zero.
module alu_md #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SH_W  = $clog2(WIDTH)
) (
    input logic     clk,
    input logic     reset,
    alu_md_if.slave bus
);
    localparam logic [4:0] OpAdd   = 5'b00000;
    localparam logic [4:0] OpSub   = 5'b00001;
    localparam logic [4:0] OpOr    = 5'b00010;
    localparam logic [4:0] OpAnd   = 5'b00011;
    localparam logic [4:0] OpXor   = 5'b00100;
    localparam logic [4:0] OpNor   = 5'b00101;
    localparam logic [4:0] OpSll   = 5'b00110;
    localparam logic [4:0] OpSrl   = 5'b00111;
    localparam logic [4:0] OpSra   = 5'b01000;
    localparam logic [4:0] OpSllv  = 5'b01001;
    localparam logic [4:0] OpSrlv  = 5'b01010;
    localparam logic [4:0] OpSrav  = 5'b01011;
    localparam logic [4:0] OpSlt   = 5'b01100;
    localparam logic [4:0] OpSlti  = 5'b01101;
    localparam logic [4:0] OpSltu  = 5'b01110;
    localparam logic [4:0] OpSltiu = 5'b01111;
    localparam logic [4:0] OpAddu  = 5'b10000;
    localparam logic [4:0] OpSubu  = 5'b10001;
    localparam logic [4:0] OpMult  = 5'b10010;
    localparam logic [4:0] OpMultu = 5'b10011;
    localparam logic [4:0] OpDiv   = 5'b10100;
    localparam logic [4:0] OpDivu  = 5'b10101;
    localparam logic [4:0] OpMthi  = 5'b10110;
    localparam logic [4:0] OpMtlo  = 5'b10111;
    localparam logic [4:0] OpMfhi  = 5'b11000;
    localparam logic [4:0] OpMflo  = 5'b11001;

    localparam logic [SH_W-1:0] CntLast = SH_W'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

    state_e           state_q, state_d;
    logic [SH_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;      // product high half / partial remainder
    logic [WIDTH-1:0] wrk_q, wrk_d;      // multiplier->product low half / dividend->quotient
    logic [WIDTH-1:0] mcand_q, mcand_d;  // multiplicand or divisor magnitude
    logic [WIDTH-1:0] dvd_q, dvd_d;      // original dividend, returned in HI on div-by-zero
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] a, b;
    logic [4:0]       op;
    logic [SH_W-1:0]  shamt;
    logic [WIDTH:0]   add_x, sub_x;
    logic             lt_s, lt_u;

    assign a     = bus.A;
    assign b     = bus.B;
    assign op    = bus.ALUOp_EX;
    assign shamt = a[SH_W-1:0];
    // One extra sign bit exposes two's-complement overflow as a mismatch of the top two bits.
    assign add_x = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    assign sub_x = {a[WIDTH-1], a} - {b[WIDTH-1], b};
    assign lt_s  = $signed(a) < $signed(b);
    assign lt_u  = a < b;

    // Combinational ALU result and overflow flag.
    always_comb begin
        bus.Result = '0;
        bus.Over   = 1'b0;
        case (op)
            OpAdd: begin
                bus.Result = add_x[WIDTH-1:0];
                bus.Over   = add_x[WIDTH] ^ add_x[WIDTH-1];
            end
            OpSub: begin
                bus.Result = sub_x[WIDTH-1:0];
                bus.Over   = sub_x[WIDTH] ^ sub_x[WIDTH-1];
            end
            OpOr:                   bus.Result = a | b;
            OpAnd:                  bus.Result = a & b;
            OpXor:                  bus.Result = a ^ b;
            OpNor:                  bus.Result = ~(a | b);
            OpSll, OpSllv:          bus.Result = b << shamt;
            OpSrl, OpSrlv:          bus.Result = b >> shamt;
            OpSra, OpSrav:          bus.Result = $unsigned($signed(b) >>> shamt);
            OpSlt, OpSlti:          bus.Result = {{(WIDTH - 1){1'b0}}, lt_s};
            OpSltu, OpSltiu:        bus.Result = {{(WIDTH - 1){1'b0}}, lt_u};
            OpAddu:                 bus.Result = a + b;
            OpSubu:                 bus.Result = a - b;
            OpMult, OpMultu, OpDiv,
            OpDivu, OpMthi, OpMtlo: bus.Result = '0;
            OpMfhi:                 bus.Result = hi_q;
            OpMflo:                 bus.Result = lo_q;
            default:                bus.Result = {{(WIDTH - 1){1'b0}}, lt_u};
        endcase
    end

    assign bus.Zero  = (a == b);
    assign bus.Great = $signed(a) > $signed(b);
    assign bus.Less  = lt_s;
    assign bus.Busy  = (state_q != StIdle);
    assign bus.Done  = done_q;
    assign bus.HI    = hi_q;
    assign bus.LO    = lo_q;

    // Operand magnitudes and result signs for the signed variants.
    logic             op_signed;
    logic [WIDTH-1:0] a_mag, b_mag;
    assign op_signed = (op == OpMult) || (op == OpDiv);
    assign a_mag     = (op_signed && a[WIDTH-1]) ? ('0 - a) : a;
    assign b_mag     = (op_signed && b[WIDTH-1]) ? ('0 - b) : b;

    // One shift-add step: add multiplicand on multiplier LSB, shift {acc,wrk} right.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_acc, mul_wrk;
    logic [2*WIDTH-1:0] prod_raw, prod_fix;
    assign mul_sum  = {1'b0, acc_q} + (wrk_q[0] ? {1'b0, mcand_q} : '0);
    assign mul_acc  = mul_sum[WIDTH:1];
    assign mul_wrk  = {mul_sum[0], wrk_q[WIDTH-1:1]};
    assign prod_raw = {mul_acc, mul_wrk};
    assign prod_fix = neg_res_q ? ('0 - prod_raw) : prod_raw;

    // One restoring step: shift next dividend bit in, keep the difference if it is non-negative.
    logic [WIDTH:0]   rem_sh, trial;
    logic [WIDTH-1:0] div_acc, div_wrk;
    assign rem_sh  = {acc_q, wrk_q[WIDTH-1]};
    assign trial   = rem_sh - {1'b0, mcand_q};
    assign div_acc = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
    assign div_wrk = {wrk_q[WIDTH-2:0], ~trial[WIDTH]};

    // Engine next-state: accept in IDLE, iterate, write HI/LO and pulse Done on completion.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        wrk_d     = wrk_q;
        mcand_d   = mcand_q;
        dvd_d     = dvd_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    case (op)
                        OpMult, OpMultu, OpDiv, OpDivu: begin
                            acc_d     = '0;
                            wrk_d     = a_mag;
                            mcand_d   = b_mag;
                            dvd_d     = a;
                            cnt_d     = '0;
                            neg_res_d = op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_rem_d = op_signed & a[WIDTH-1];
                            state_d   = (op == OpMult || op == OpMultu) ? StMul : StDiv;
                        end
                        OpMthi:  hi_d = a;
                        OpMtlo:  lo_d = a;
                        default: ;
                    endcase
                end
            end
            StMul: begin
                acc_d = mul_acc;
                wrk_d = mul_wrk;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    hi_d    = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d    = prod_fix[WIDTH-1:0];
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            StDiv: begin
                acc_d = div_acc;
                wrk_d = div_wrk;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                if (mcand_q == '0) begin
                    lo_d = '1;
                    hi_d = dvd_q;
                end else begin
                    lo_d = neg_res_q ? ('0 - wrk_q) : wrk_q;
                    hi_d = neg_rem_q ? ('0 - acc_q) : acc_q;
                end
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; synchronous reset wins over any start and aborts an operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            acc_q     <= '0;
            wrk_q     <= '0;
            mcand_q   <= '0;
            dvd_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            wrk_q     <= wrk_d;
            mcand_q   <= mcand_d;
            dvd_q     <= dvd_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end
endmodule

// File: tb/tb_alu_md.sv
// Directed bench for alu_md: 32-bit instance for most tests, 16-bit instance for width checks.
module tb_alu_md;
    localparam logic [4:0] OpAdd   = 5'b00000;
    localparam logic [4:0] OpSub   = 5'b00001;
    localparam logic [4:0] OpOr    = 5'b00010;
    localparam logic [4:0] OpXor   = 5'b00100;
    localparam logic [4:0] OpNor   = 5'b00101;
    localparam logic [4:0] OpSll   = 5'b00110;
    localparam logic [4:0] OpSrl   = 5'b00111;
    localparam logic [4:0] OpSra   = 5'b01000;
    localparam logic [4:0] OpSllv  = 5'b01001;
    localparam logic [4:0] OpSrav  = 5'b01011;
    localparam logic [4:0] OpSlt   = 5'b01100;
    localparam logic [4:0] OpSltu  = 5'b01110;
    localparam logic [4:0] OpAddu  = 5'b10000;
    localparam logic [4:0] OpSubu  = 5'b10001;
    localparam logic [4:0] OpMult  = 5'b10010;
    localparam logic [4:0] OpMultu = 5'b10011;
    localparam logic [4:0] OpDiv   = 5'b10100;
    localparam logic [4:0] OpDivu  = 5'b10101;
    localparam logic [4:0] OpMthi  = 5'b10110;
    localparam logic [4:0] OpMtlo  = 5'b10111;
    localparam logic [4:0] OpMfhi  = 5'b11000;
    localparam logic [4:0] OpMflo  = 5'b11001;
    localparam logic [4:0] OpUndef = 5'b11010;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    alu_md_if #(.WIDTH(32)) bus ();
    alu_md_if #(.WIDTH(16)) bus16 ();

    alu_md #(.WIDTH(32)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    alu_md #(.WIDTH(16)) dut16 (
        .clk  (clk),
        .reset(reset),
        .bus  (bus16)
    );

    // Launch a multiply/divide at the current negedge, scramble operands while busy,
    // and return the number of busy cycles plus what was seen in the first idle cycle.
    task automatic run_md(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int n, output logic done, output logic [31:0] hi,
                          output logic [31:0] lo);
        bus.ALUOp_EX = op;
        bus.A        = a;
        bus.B        = b;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (bus.Busy === 1'b1 && n < 200) begin
            n++;
            bus.A = $urandom;
            bus.B = $urandom;
            @(negedge clk);
        end
        done = bus.Done;
        hi   = bus.HI;
        lo   = bus.LO;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.ALUOp_EX   = OpAdd;
        bus.A          = '0;
        bus.B          = '0;
        bus16.start    = 1'b0;
        bus16.ALUOp_EX = OpAdd;
        bus16.A        = '0;
        bus16.B        = '0;
        repeat (2) @(negedge clk);
        checks++; if (bus.Busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.Busy); end
        checks++; if (bus.Done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.Done); end
        checks++; if (bus.HI !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=0", bus.HI); end
        checks++; if (bus.LO !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=0", bus.LO); end
        checks++; if (bus16.Busy !== 1'b0) begin failures++; $display("FAIL reset_busy16 got=%b exp=0", bus16.Busy); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_combo();
        logic [4:0]  ops [14];
        logic [31:0] av [14];
        logic [31:0] bv [14];
        logic [31:0] rv [14];
        logic        ov [14];
        ops = '{OpAdd, OpAddu, OpSub, OpSra, OpSrl, OpSllv, OpSlt, OpSltu, OpNor, OpXor,
                OpUndef, OpUndef, OpSubu, OpSrav};
        av  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h4, 32'h4, 32'h24, 32'hFFFFFFFF,
                32'hFFFFFFFF, 32'hF0F0F0F0, 32'hFF00FF00, 32'h1, 32'hFFFFFFFF, 32'h0, 32'h21};
        bv  = '{32'h1, 32'h1, 32'h1, 32'h80000000, 32'h80000000, 32'h1, 32'h1, 32'h1,
                32'h0F0F0000, 32'h0FF00FF0, 32'h2, 32'h1, 32'h1, 32'h80000000};
        rv  = '{32'h80000000, 32'h80000000, 32'h7FFFFFFF, 32'hF8000000, 32'h08000000, 32'h10,
                32'h1, 32'h0, 32'h00000F0F, 32'hF0F0F0F0, 32'h1, 32'h0, 32'hFFFFFFFF, 32'hC0000000};
        ov  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 14; i++) begin
            bus.ALUOp_EX = ops[i];
            bus.A        = av[i];
            bus.B        = bv[i];
            #1;
            checks++;
            if (bus.Result !== rv[i]) begin
                failures++;
                $display("FAIL combo_result[%0d] op=%b got=%h exp=%h", i, ops[i], bus.Result, rv[i]);
            end
            checks++;
            if (bus.Over !== ov[i]) begin
                failures++;
                $display("FAIL combo_over[%0d] op=%b got=%b exp=%b", i, ops[i], bus.Over, ov[i]);
            end
            @(negedge clk);
        end
        // Signed compare flags: equal, greater, less.
        bus.ALUOp_EX = OpOr;
        bus.A = 32'h5; bus.B = 32'h5; #1;
        checks++; if ({bus.Zero, bus.Great, bus.Less} !== 3'b100) begin failures++; $display("FAIL flags_eq got=%b exp=100", {bus.Zero, bus.Great, bus.Less}); end
        bus.A = 32'h1; bus.B = 32'hFFFFFFFF; #1;
        checks++; if ({bus.Zero, bus.Great, bus.Less} !== 3'b010) begin failures++; $display("FAIL flags_gt got=%b exp=010", {bus.Zero, bus.Great, bus.Less}); end
        bus.A = 32'h80000000; bus.B = 32'h7FFFFFFF; #1;
        checks++; if ({bus.Zero, bus.Great, bus.Less} !== 3'b001) begin failures++; $display("FAIL flags_lt got=%b exp=001", {bus.Zero, bus.Great, bus.Less}); end
        @(negedge clk);
    endtask

    task automatic test_mult();
        int n; logic d; logic [31:0] hi, lo;
        run_md(OpMult, 32'hFFFFFFFF, 32'h2, n, d, hi, lo);
        checks++; if (n != 32) begin failures++; $display("FAIL mult_busy got=%0d exp=32", n); end
        checks++; if (d !== 1'b1) begin failures++; $display("FAIL mult_done got=%b exp=1", d); end
        checks++; if (hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
        checks++; if (lo !== 32'hFFFFFFFE) begin failures++; $display("FAIL mult_lo got=%h exp=fffffffe", lo); end
        @(negedge clk);
        checks++; if (bus.Done !== 1'b0) begin failures++; $display("FAIL mult_done_fall got=%b exp=0", bus.Done); end
        bus.ALUOp_EX = OpMfhi; #1;
        checks++; if (bus.Result !== 32'hFFFFFFFF) begin failures++; $display("FAIL mfhi got=%h exp=ffffffff", bus.Result); end
        bus.ALUOp_EX = OpMflo; #1;
        checks++; if (bus.Result !== 32'hFFFFFFFE) begin failures++; $display("FAIL mflo got=%h exp=fffffffe", bus.Result); end
        @(negedge clk);
        run_md(OpMultu, 32'hFFFFFFFF, 32'h2, n, d, hi, lo);
        checks++; if (hi !== 32'h1 || lo !== 32'hFFFFFFFE) begin failures++; $display("FAIL multu got=%h_%h exp=00000001_fffffffe", hi, lo); end
        @(negedge clk);
        run_md(OpMult, 32'hFFFFFFFD, 32'hFFFFFFFB, n, d, hi, lo);
        checks++; if (hi !== 32'h0 || lo !== 32'hF) begin failures++; $display("FAIL mult_negneg got=%h_%h exp=00000000_0000000f", hi, lo); end
        @(negedge clk);
    endtask

    task automatic test_div();
        int n; logic d; logic [31:0] hi, lo;
        run_md(OpDiv, 32'hFFFFFFF9, 32'h2, n, d, hi, lo);
        checks++; if (n != 33) begin failures++; $display("FAIL div_busy got=%0d exp=33", n); end
        checks++; if (d !== 1'b1) begin failures++; $display("FAIL div_done got=%b exp=1", d); end
        checks++; if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_m7_2 got hi=%h lo=%h exp hi=ffffffff lo=fffffffd", hi, lo); end
        @(negedge clk);
        run_md(OpDivu, 32'h7, 32'h2, n, d, hi, lo);
        checks++; if (lo !== 32'h3 || hi !== 32'h1) begin failures++; $display("FAIL divu_7_2 got hi=%h lo=%h exp hi=1 lo=3", hi, lo); end
        @(negedge clk);
        run_md(OpDiv, 32'h7, 32'hFFFFFFFE, n, d, hi, lo);
        checks++; if (lo !== 32'hFFFFFFFD || hi !== 32'h1) begin failures++; $display("FAIL div_7_m2 got hi=%h lo=%h exp hi=1 lo=fffffffd", hi, lo); end
        @(negedge clk);
        run_md(OpDiv, 32'h5, 32'h0, n, d, hi, lo);
        checks++; if (n != 33) begin failures++; $display("FAIL div0_busy got=%0d exp=33", n); end
        checks++; if (lo !== 32'hFFFFFFFF || hi !== 32'h5) begin failures++; $display("FAIL div0 got hi=%h lo=%h exp hi=5 lo=ffffffff", hi, lo); end
        @(negedge clk);
        run_md(OpDiv, 32'h80000000, 32'hFFFFFFFF, n, d, hi, lo);
        checks++; if (lo !== 32'h80000000 || hi !== 32'h0) begin failures++; $display("FAIL div_min_m1 got hi=%h lo=%h exp hi=0 lo=80000000", hi, lo); end
        @(negedge clk);
        run_md(OpDivu, 32'hFFFFFFFF, 32'h10, n, d, hi, lo);
        checks++; if (lo !== 32'h0FFFFFFF || hi !== 32'hF) begin failures++; $display("FAIL divu_big got hi=%h lo=%h exp hi=f lo=0fffffff", hi, lo); end
        @(negedge clk);
    endtask

    task automatic test_ignore();
        int n;
        // Known LO via mtlo, so an illegally accepted mtlo during Busy becomes visible.
        bus.ALUOp_EX = OpMtlo; bus.A = 32'h0BADF00D; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.ALUOp_EX = OpMult; bus.A = 32'hFFFFFFFF; bus.B = 32'h2; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (bus.Busy === 1'b1 && n < 200) begin
            n++;
            bus.start = 1'b0;
            bus.ALUOp_EX = OpMult;
            if (n == 3) begin
                bus.start = 1'b1; bus.A = 32'h5; bus.B = 32'h7;
            end else if (n == 4) begin
                bus.ALUOp_EX = OpMflo; #1;
                checks++; if (bus.Result !== 32'h0BADF00D) begin failures++; $display("FAIL mflo_busy got=%h exp=0badf00d", bus.Result); end
            end else if (n == 5) begin
                bus.start = 1'b1; bus.ALUOp_EX = OpMtlo; bus.A = 32'h12345678;
            end else if (n == 6) begin
                checks++; if (bus.LO !== 32'h0BADF00D) begin failures++; $display("FAIL mtlo_busy got=%h exp=0badf00d", bus.LO); end
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        checks++; if (n != 32) begin failures++; $display("FAIL ignore_busy got=%0d exp=32", n); end
        checks++; if (bus.HI !== 32'hFFFFFFFF || bus.LO !== 32'hFFFFFFFE) begin failures++; $display("FAIL ignore_result got=%h_%h exp=ffffffff_fffffffe", bus.HI, bus.LO); end
        @(negedge clk);
        checks++; if (bus.Busy !== 1'b0) begin failures++; $display("FAIL ignore_no_restart got=%b exp=0", bus.Busy); end
    endtask

    task automatic test_back_to_back();
        int n1, n2; logic d1, d2; logic [31:0] hi1, lo1, hi2, lo2;
        run_md(OpDivu, 32'h7, 32'h2, n1, d1, hi1, lo1);
        run_md(OpMultu, 32'h3, 32'h4, n2, d2, hi2, lo2);
        checks++; if (n1 != 33 || hi1 !== 32'h1 || lo1 !== 32'h3) begin failures++; $display("FAIL b2b_first got n=%0d hi=%h lo=%h exp n=33 hi=1 lo=3", n1, hi1, lo1); end
        checks++; if (n2 != 32 || d2 !== 1'b1) begin failures++; $display("FAIL b2b_second_timing got n=%0d done=%b exp n=32 done=1", n2, d2); end
        checks++; if (hi2 !== 32'h0 || lo2 !== 32'hC) begin failures++; $display("FAIL b2b_second got hi=%h lo=%h exp hi=0 lo=c", hi2, lo2); end
        @(negedge clk);
    endtask

    task automatic test_move();
        bus.ALUOp_EX = OpMthi; bus.A = 32'hCAFEBABE; bus.start = 1'b1;
        @(negedge clk);
        bus.ALUOp_EX = OpMtlo; bus.A = 32'h13572468;
        checks++; if (bus.HI !== 32'hCAFEBABE) begin failures++; $display("FAIL mthi got=%h exp=cafebabe", bus.HI); end
        checks++; if (bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin failures++; $display("FAIL mthi_flags got busy=%b done=%b exp 0 0", bus.Busy, bus.Done); end
        @(negedge clk);
        bus.start = 1'b0;
        checks++; if (bus.LO !== 32'h13572468) begin failures++; $display("FAIL mtlo got=%h exp=13572468", bus.LO); end
        @(negedge clk);
        checks++; if (bus.Done !== 1'b0 || bus.HI !== 32'hCAFEBABE) begin failures++; $display("FAIL move_after got done=%b hi=%h exp 0 cafebabe", bus.Done, bus.HI); end
    endtask

    task automatic test_reset_abort();
        int n;
        bus.ALUOp_EX = OpMult; bus.A = 32'h3; bus.B = 32'h5; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (bus.Busy === 1'b1 && n < 10) begin
            n++;
            if (n == 10) reset = 1'b1;
            @(negedge clk);
        end
        checks++; if (n != 10) begin failures++; $display("FAIL abort_reach got=%0d exp=10", n); end
        checks++; if (bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin failures++; $display("FAIL abort_flags got busy=%b done=%b exp 0 0", bus.Busy, bus.Done); end
        checks++; if (bus.HI !== 32'h0 || bus.LO !== 32'h0) begin failures++; $display("FAIL abort_hilo got=%h_%h exp=0_0", bus.HI, bus.LO); end
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++; if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) begin failures++; $display("FAIL abort_after got busy=%b done=%b exp 0 0", bus.Busy, bus.Done); end
        end
        // Reset and start in the same cycle: reset wins.
        reset = 1'b1; bus.ALUOp_EX = OpMult; bus.A = 32'h3; bus.B = 32'h5; bus.start = 1'b1;
        @(negedge clk);
        checks++; if (bus.Busy !== 1'b0) begin failures++; $display("FAIL reset_priority got=%b exp=0", bus.Busy); end
        reset = 1'b0; bus.start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_width16();
        int n;
        bus16.ALUOp_EX = OpSll; bus16.A = 16'h0013; bus16.B = 16'h0001; #1;
        checks++; if (bus16.Result !== 16'h0008) begin failures++; $display("FAIL w16_sll got=%h exp=0008", bus16.Result); end
        bus16.ALUOp_EX = OpAdd; bus16.A = 16'h7FFF; bus16.B = 16'h0001; #1;
        checks++; if (bus16.Result !== 16'h8000 || bus16.Over !== 1'b1) begin failures++; $display("FAIL w16_add got=%h over=%b exp=8000 over=1", bus16.Result, bus16.Over); end
        @(negedge clk);
        bus16.ALUOp_EX = OpMultu; bus16.A = 16'hFFFF; bus16.B = 16'hFFFF; bus16.start = 1'b1;
        @(negedge clk);
        bus16.start = 1'b0;
        n = 0;
        while (bus16.Busy === 1'b1 && n < 200) begin
            n++;
            bus16.A = 16'h1234;
            @(negedge clk);
        end
        checks++; if (n != 16 || bus16.Done !== 1'b1) begin failures++; $display("FAIL w16_multu_timing got n=%0d done=%b exp n=16 done=1", n, bus16.Done); end
        checks++; if (bus16.HI !== 16'hFFFE || bus16.LO !== 16'h0001) begin failures++; $display("FAIL w16_multu got=%h_%h exp=fffe_0001", bus16.HI, bus16.LO); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_combo();
        test_mult();
        test_div();
        test_ignore();
        test_back_to_back();
        test_move();
        test_reset_abort();
        test_width16();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
endmodule
